writeable_registers: RTL

- Processor-facing memory-IO slave that owns a bank of control registers.
- The processor writes the registers with byte, half or word stores. A peripheral consumes the register contents from the flattened o_registers bus.
- Per-register dirty flags and an ack handshake tell the peripheral when new values are present.
- Readback of the current register values is supported through the same request port.

---
 rtl/writeable_registers.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/writeable_registers.sv
// Processor-facing register bank: byte/half/word stores with per-bit write masks,
// registered readback responses, and per-register dirty flags with an ack handshake.
package writeable_registers_pkg;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned MEM_COUNT_W = 3;
    localparam int unsigned MEM_CODE_W  = 2;

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd3;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;
endpackage

module writeable_registers
    import writeable_registers_pkg::*;
#(
    parameter int unsigned                 REG_COUNT   = 4,
    parameter logic [ADDR_W-1:0]           ADDR_START  = '0,
    parameter logic [REG_COUNT*WORD_W-1:0] RESET_VALUE = '0,
    parameter logic [REG_COUNT*WORD_W-1:0] WRITE_MASK  = '1
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [ADDR_W-1:0]           i_req_addr,
    input  logic [MEM_COUNT_W-1:0]      i_req_count,
    input  logic                        i_req_wr,
    input  logic [WORD_W-1:0]           i_req_wr_data,
    output logic [WORD_W-1:0]           o_res_rd_data,
    output logic [MEM_CODE_W-1:0]       o_res_code,
    output logic [REG_COUNT*WORD_W-1:0] o_registers,
    output logic [REG_COUNT-1:0]        o_dirty,
    input  logic [REG_COUNT-1:0]        i_ack,
    output logic [REG_COUNT-1:0]        o_wr_pulse
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SEL_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [WORD_W-1:0]     r_regs [REG_COUNT];
    logic [WORD_W-1:0]     w_mask [REG_COUNT];
    logic [REG_COUNT-1:0]  r_dirty;
    logic [REG_COUNT-1:0]  r_wr_pulse;
    logic [WORD_W-1:0]     r_rd_data;
    logic [MEM_CODE_W-1:0] r_code;

    logic [ADDR_W-1:0]     w_offset;
    logic [1:0]            w_lane;
    logic [IDX_W-1:0]      w_index;
    logic [SEL_W-1:0]      w_sel;
    logic [WORD_W-1:0]     w_cur;
    logic [WORD_W-1:0]     w_cur_shift;
    logic [WORD_W-1:0]     w_lane_data;
    logic [WORD_W-1:0]     w_bit_en;
    logic [WORD_W-1:0]     w_new;
    logic [WORD_W-1:0]     w_rd_data;
    logic [3:0]            w_byte_en;
    logic                  w_misaligned;
    logic                  w_bad_count;
    logic                  w_out_of_range;
    logic                  w_active;
    logic                  w_err;

    genvar g;
    generate
        for (g = 0; g < int'(REG_COUNT); g++) begin : g_flat
            assign o_registers[g*WORD_W +: WORD_W] = r_regs[g];
            assign w_mask[g] = WRITE_MASK[g*WORD_W +: WORD_W];
        end
    endgenerate

    // Full-width subtraction so addresses below the window wrap to a huge index.
    assign w_offset       = i_req_addr - ADDR_START;
    assign w_lane         = w_offset[1:0];
    assign w_index        = w_offset[ADDR_W-1:2];
    assign w_sel          = SEL_W'(w_index);
    assign w_out_of_range = (i_req_addr < ADDR_START) || (w_index >= IDX_W'(REG_COUNT));
    assign w_cur          = r_regs[w_sel];
    assign w_cur_shift    = w_cur >> {w_lane, 3'b000};
    assign w_active       = (i_req_count != MEM_COUNT_NONE);
    assign w_err          = w_misaligned || w_out_of_range || w_bad_count;

    // Size decode: lane enables, replicated write data and zero-extended readback.
    always_comb begin
        w_byte_en    = 4'h0;
        w_lane_data  = i_req_wr_data;
        w_rd_data    = '0;
        w_misaligned = 1'b0;
        w_bad_count  = 1'b0;
        case (i_req_count)
            MEM_COUNT_BYTE: begin
                w_byte_en   = 4'b0001 << w_lane;
                w_lane_data = {4{i_req_wr_data[7:0]}};
                w_rd_data   = WORD_W'(w_cur_shift[7:0]);
            end
            MEM_COUNT_HALF: begin
                w_misaligned = w_lane[0];
                w_byte_en    = 4'b0011 << w_lane;
                w_lane_data  = {2{i_req_wr_data[15:0]}};
                w_rd_data    = WORD_W'(w_cur_shift[15:0]);
            end
            MEM_COUNT_WORD: begin
                w_misaligned = (w_lane != 2'd0);
                w_byte_en    = 4'hF;
                w_rd_data    = w_cur;
            end
            default: w_bad_count = 1'b1;
        endcase
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_bit_en[b*8 +: 8] = {8{w_byte_en[b]}} & w_mask[w_sel][b*8 +: 8];
        end
        w_new = (w_cur & ~w_bit_en) | (w_lane_data & w_bit_en);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                r_regs[i] <= RESET_VALUE[i*WORD_W +: WORD_W];
            end
            r_dirty    <= '0;
            r_wr_pulse <= '0;
            r_rd_data  <= '0;
            r_code     <= MEM_CODE_INVALID;
        end else begin
            r_wr_pulse <= '0;
            r_dirty    <= r_dirty & ~i_ack;
            if (w_active) begin
                if (w_err) begin
                    r_code    <= w_misaligned ? MEM_CODE_MISALIGNED : MEM_CODE_INVALID;
                    r_rd_data <= '0;
                end else if (i_req_wr) begin
                    // Dirty/pulse fire even when the mask blocks every bit; write beats ack.
                    r_regs[w_sel]     <= w_new;
                    r_dirty[w_sel]    <= 1'b1;
                    r_wr_pulse[w_sel] <= 1'b1;
                    r_code            <= MEM_CODE_WRITE;
                    r_rd_data         <= '0;
                end else begin
                    r_code    <= MEM_CODE_READ;
                    r_rd_data <= w_rd_data;
                end
            end
        end
    end

    assign o_dirty       = r_dirty;
    assign o_wr_pulse    = r_wr_pulse;
    assign o_res_rd_data = r_rd_data;
    assign o_res_code    = r_code;

endmodule
